// File: rtl/stopwatch_uart_pkg.sv
// stopwatch_uart_pkg: command bytes, ASCII constants and FSM encoding for the stopwatch UART front end
package stopwatch_uart_pkg;
    localparam logic [7:0] CMD_GO      = 8'h67;
    localparam logic [7:0] CMD_STOP    = 8'h73;
    localparam logic [7:0] CMD_CLR     = 8'h63;
    localparam logic [7:0] CMD_RPT     = 8'h72;
    localparam logic [7:0] CMD_GO_UC   = 8'h47;
    localparam logic [7:0] CMD_STOP_UC = 8'h53;
    localparam logic [7:0] CMD_CLR_UC  = 8'h43;
    localparam logic [7:0] CMD_RPT_UC  = 8'h52;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    typedef enum logic [1:0] {IDLE, DECODE, SEND} state_t;
    function automatic logic cmd_match(input logic [7:0] b, input logic [7:0] lc, input logic [7:0] uc, input logic ci);
        return (b == lc) || (ci && b == uc);
    endfunction
endpackage

// File: rtl/rpt_char_mux.sv
// rpt_char_mux: maps report character index and snapshotted digits to the ASCII byte to send
module rpt_char_mux
    import stopwatch_uart_pkg::*;
(
    input  logic [2:0] idx,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic [7:0] ch
);
    always_comb begin
        ch = idx == 3'd0 ? ASCII_ZERO + {4'h0, d2} :
             idx == 3'd1 ? ASCII_ZERO + {4'h0, d1} :
             idx == 3'd2 ? ASCII_DOT :
             idx == 3'd3 ? ASCII_ZERO + {4'h0, d0} :
             idx == 3'd4 ? ASCII_CR :
             idx == 3'd5 ? ASCII_LF : 8'h00;
    end
endmodule

// File: rtl/stopwatch_uart_ctrl.sv
// stopwatch_uart_ctrl: decodes UART command bytes into stopwatch go/clr and sends BCD time reports
module stopwatch_uart_ctrl
    import stopwatch_uart_pkg::*;
#(
    parameter bit CASE_INSENSITIVE = 1'b1,
    parameter bit TERM_CRLF        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       go,
    output logic       clr
);
    state_t     state, state_nx;
    logic [7:0] cmd;
    logic [2:0] idx;
    logic [3:0] s2, s1, s0;
    logic [7:0] ch;
    logic       is_go, is_stop, is_clr, is_rpt, last;

    rpt_char_mux u_mux (.idx(idx), .d2(s2), .d1(s1), .d0(s0), .ch(ch));

    always_comb begin
        is_go    = cmd_match(cmd, CMD_GO, CMD_GO_UC, CASE_INSENSITIVE);
        is_stop  = cmd_match(cmd, CMD_STOP, CMD_STOP_UC, CASE_INSENSITIVE);
        is_clr   = cmd_match(cmd, CMD_CLR, CMD_CLR_UC, CASE_INSENSITIVE);
        is_rpt   = cmd_match(cmd, CMD_RPT, CMD_RPT_UC, CASE_INSENSITIVE);
        last     = idx == (TERM_CRLF ? 3'd5 : 3'd4);
        // reset gates the pop so a held reset never drains the rx FIFO
        rd_uart  = reset && state == IDLE && !rx_empty;
        wr_uart  = state == SEND && !tx_full;
        w_data   = state == SEND ? ch : 8'h00;
        state_nx = state == IDLE   ? (rd_uart ? DECODE : IDLE) :
                   state == DECODE ? (is_rpt ? SEND : IDLE) :
                   state == SEND   ? (wr_uart && last ? IDLE : SEND) : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cmd   <= 8'h00;
            idx   <= 3'd0;
            s2    <= 4'd0;
            s1    <= 4'd0;
            s0    <= 4'd0;
            go    <= 1'b0;
            clr   <= 1'b0;
        end else begin
            state <= state_nx;
            clr   <= state == DECODE && is_clr;
            if (rd_uart) cmd <= r_data;
            if (state == DECODE && is_go) go <= 1'b1;
            else if (state == DECODE && is_stop) go <= 1'b0;
            if (state == DECODE && is_rpt) begin
                idx <= 3'd0;
                s2  <= d2;
                s1  <= d1;
                s0  <= d0;
            end else if (wr_uart) begin
                idx <= idx + 3'd1;
            end
        end
    end
endmodule

// File: doc/stopwatch_uart_ctrl.md
# stopwatch_uart_ctrl

Command front end for the UART-controlled stopwatch. It pops ASCII command bytes from the UART receive FIFO, turns them into stopwatch `go`/`clr` controls, and on request writes the current BCD time back into the UART transmit FIFO as an ASCII string. It sits between the `uart` block, on both its rx and tx FIFO sides, and the stopwatch counter.

## Interface
Parameters:
- `CASE_INSENSITIVE`, 1: when 1, upper-case command letters are accepted as well as lower-case.
- `TERM_CRLF`, 1: when 1, a report ends with CR LF; when 0, it ends with CR only.

Ports:
- `clk`  in  1  single system clock
- `reset`  in  1  asynchronous, active-low reset
- `rx_empty`  in  1  rx FIFO empty; when low, `r_data` is valid (first-word fall-through)
- `r_data`  in  8  head byte of the rx FIFO
- `rd_uart`  out  1  pops the rx FIFO head; one-cycle pulse
- `tx_full`  in  1  tx FIFO full
- `wr_uart`  out  1  pushes `w_data` into the tx FIFO; one-cycle pulse per byte
- `w_data`  out  8  ASCII byte to transmit
- `d2`, `d1`, `d0`  in  4 each  stopwatch BCD digits (d2 = most significant; d0 = tenths)
- `go`  out  1  stopwatch run enable, level
- `clr`  out  1  stopwatch clear, one-cycle pulse

## Operation
Commands (ASCII):
- `g` 0x67: set `go`=1.
- `s` 0x73: set `go`=0.
- `c` 0x63: pulse `clr`; `go` is unchanged.
- `r` 0x72: snapshot `d2`/`d1`/`d0`, then transmit d2, d1, '.', d0, CR (0x0D), and LF (0x0A) if `TERM_CRLF`=1. Digits are sent as 0x30+digit.
- Any other byte is popped and ignored. Upper-case forms (0x47, 0x53, 0x43, 0x52) are accepted only when `CASE_INSENSITIVE`=1.

FSM states:
- IDLE: if `rx_empty`=0, then `rd_uart`=1, the byte is latched and the next state is DECODE. Otherwise stay in IDLE.
- DECODE: apply the command. For `r`, capture the digits, set the index to 0 and go to SEND. For all other bytes, return to IDLE.
- SEND: `wr_uart` = !`tx_full`; `w_data` = char[index]. On each accepted write, index+1. After the last character (index 5, or 4 when `TERM_CRLF`=0), return to IDLE.

Rules:
- `rd_uart` and `wr_uart` are combinational from state and the FIFO flags. They are never asserted together.
- `w_data` is 0x00 outside SEND.
- The rx FIFO is not popped while in SEND. Commands received during a report wait in the FIFO and are processed in order afterwards.
- Digits are snapshotted in DECODE. Counter changes during SEND do not alter the string being sent.
- Digits above 9 are sent as 0x30+value; they are not validated.
- `tx_full` stalls SEND indefinitely with no timeout. The index and characters hold during the stall.
- Repeated `g` while running, or `s` while stopped: no change.
- `reset` asserted at any time, including mid-report: state=IDLE, `go`=0, `clr`=0, index=0. Any partial report is abandoned and the tx FIFO contents are not touched.

## Timing
- Reset values: `go`=0, `clr`=0, `rd_uart`=0, `wr_uart`=0, `w_data`=0x00.
- Cycle 0: IDLE with `rx_empty`=0, so `rd_uart`=1.
- Cycle 1: DECODE.
- `go` changes at the edge ending cycle 1.
- `clr` is high for exactly cycle 2.
- For `r`, the first `wr_uart` can occur in cycle 2.
- Back-to-back commands: the next pop is possible in cycle 2. Minimum of 2 cycles per non-report command.
- Report with `tx_full`=0 throughout: 6 consecutive `wr_uart` cycles (5 when `TERM_CRLF`=0), then IDLE.
- `go` and `clr` are registered outputs. `rd_uart`, `wr_uart` and `w_data` are combinational outputs of the registered state.

## Structure
- Shared package `stopwatch_uart_pkg` holds:
  - command byte constants (`CMD_GO`, `CMD_STOP`, `CMD_CLR`, `CMD_RPT`, plus upper-case variants);
  - `ASCII_ZERO`, `ASCII_DOT`, `ASCII_CR`, `ASCII_LF`;
  - the FSM state encoding.
- One sub-module, `rpt_char_mux`: combinational; maps index and the snapshotted digits to the ASCII byte.
- Everything else stays flat in `stopwatch_uart_ctrl`.

## Test plan
- Reset: hold `reset`=0 with `rx_empty`=0 and `r_data`=0x67. Required: `go`=0, `rd_uart`=0, `wr_uart`=0. After release, `go`=1 two cycles later.
- Command stream g, c, s (FIFO model, FWFT): `go` rises; `clr` pulses for one cycle with `go` still 1; then `go` falls. Exactly 3 `rd_uart` pulses.
- Report: digits 4,2,7, then `r`. Required tx bytes: 0x34 0x32 0x2E 0x37 0x0D 0x0A on 6 consecutive cycles. Repeat with `TERM_CRLF`=0: 5 bytes, with no 0x0A.
- Backpressure: `tx_full`=1 for 10 cycles after the second report byte. Required: no `wr_uart` and `w_data` stable during the stall, then the remaining 4 bytes are sent. Digits changed to 9,9,9 mid-report must not appear in the string.
- Queued and unknown bytes: FIFO holds r, x, G with `CASE_INSENSITIVE`=1. Required: full report first; `x` popped with no effect; then `go`=1. With `CASE_INSENSITIVE`=0, `G` is ignored.
- Reset mid-report: assert `reset` after the third byte. Required: `wr_uart` drops immediately, `go`=0, and the next command after release is decoded normally.
